proc_hier_top: RTL and testbench
================================

Name: proc_hier_top

Overview:
- Single-cycle, unpipelined 16-bit processor core with trace outputs.
- Each clock one instruction is fetched, decoded, executed and committed:
  - register writes land on the clock edge;
  - memory writes are requested combinationally and land on the same edge.
- Instruction and data memories are external, with combinational read.
- Commit-trace outputs feed the simulation log/trace checker.

Parameters:
- none

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous active-low reset.
- inst_addr  out  16  instruction fetch address (= PC).
- inst_data  in  16  instruction at inst_addr; combinational.
- mem_addr  out  16  data address (ALU result).
- mem_wdata  out  16  store data.
- mem_rdata  in  16  load data; combinational from mem_addr.
- mem_rd  out  1  load in progress.
- mem_wr  out  1  store in progress; external memory writes on rising clk.
- trc_pc  out  16  PC of current instruction.
- trc_inst  out  16  current instruction.
- trc_regwrite  out  1  register file write enable.
- trc_wreg  out  3  register written.
- trc_wdata  out  16  data written to register.
- halt  out  1  HALT executing, or core halted.
- cycle_count  out  32  cycles since reset release.

Behaviour:
- State: PC[15:0], 8 x 16-bit registers R0-R7 (R0 ordinary), halted flag, cycle_count.
- Reset (rst=0, asynchronous):
  - PC=0, all registers=0, halted=0, cycle_count=0.
  - mem_wr=0 and trc_regwrite=0 while in reset.
- cycle_count: +1 every rising clk while rst=1; wraps at 2^32.
- Register file: reads combinational; write on rising clk; a newly written value is visible from the next cycle.
- PC: byte address; default next PC = PC+2 (16-bit wrap).
- Field layout:
  - opcode = inst[15:11], Rs = inst[10:8], Rt = inst[7:5].
  - I-format: Rd = inst[7:5], imm5 = inst[4:0].
  - R-format: Rd = inst[4:2].
- Instruction set:
  - 00000 HALT: halt=1; no reg/mem write; PC holds; halted latches; core stays halted until reset.
  - 00001 NOP.
  - 01000 ADDI: Rd = Rs + sext(imm5).
  - 01001 SUBI: Rd = sext(imm5) - Rs.
  - 01010 XORI: Rd = Rs ^ zext(imm5).
  - 01011 ANDNI: Rd = Rs & ~zext(imm5).
  - 10000 ST: Mem[Rs+sext(imm5)] = Rd; mem_wr=1; mem_wdata = Rd.
  - 10001 LD: Rd = Mem[Rs+sext(imm5)]; mem_rd=1.
  - 10011 STU: Mem[Rs+sext(imm5)] = Rd, and Rs = Rs+sext(imm5), in the same cycle. mem_wdata uses the old Rd; trc_wreg = Rs.
  - 11011 R-type, function inst[1:0]:
    - 00 ADD: Rd = Rs+Rt.
    - 01 SUB: Rd = Rt-Rs.
    - 10 XOR: Rd = Rs^Rt.
    - 11 ANDN: Rd = Rs&~Rt.
  - 11000 LBI: Rs = sext(inst[7:0]).
  - 01100 BEQZ: if Rs==0 then PC = PC+2+sext(inst[7:0]).
  - 01101 BNEZ: if Rs!=0 then PC = PC+2+sext(inst[7:0]).
  - 00100 J: PC = PC+2+sext(inst[10:0]).
  - Any other opcode behaves as NOP.
- Arithmetic: 16-bit two's complement, overflow discarded, no flags.
- mem_addr: driven with the ALU result for every instruction; meaningful only when mem_rd or mem_wr is 1.
- mem_rd and mem_wr: never both 1.
- Trace outputs: combinational views of the current instruction's commit.
  - trc_wdata = value written (load data for LD).
  - mem_rd/mem_wr/halt are 0 when the current instruction does not use them.
- Halted state (after HALT commits):
  - halt stays 1; trc_pc stays at the HALT address.
  - No further reg/mem writes.
  - cycle_count keeps counting.
- Reset asserted mid-operation aborts the current instruction; nothing commits on that edge.

Test Plan:
- Reset then LBI R1,#-3 (0xC1FD) -> trc_regwrite=1, trc_wreg=1, trc_wdata=0xFFFD; next trc_pc=0x0002.
- R1=5, R2=7; ADD R3=R1+R2 (0xD94C) -> R3=0x000C. Repeat with SUB function -> R3=0x0002.
- R1=0x0010, R2=0xABCD; ST R2,[R1+2] -> mem_wr=1, mem_addr=0x0012, mem_wdata=0xABCD. Then LD R4,[R1+2] -> mem_rd=1, trc_wdata=0xABCD.
- STU R2,[R1-1] with R1=0x0010 -> mem_addr=0x000F, trc_wreg=1, trc_wdata=0x000F, mem_wr=1.
- R1=0 at PC=0x0008; BEQZ R1,#4 -> next PC=0x000E. BNEZ R1,#4 -> next PC=0x000A. J #-2 at PC 0x0020 -> next PC 0x0020.
- HALT at PC 0x0006 -> halt=1 and PC stays 0x0006 for 5+ cycles; no writes; cycle_count keeps incrementing. Reset -> PC=0, halt=0, cycle_count=0.

Source files
------------

// File: rtl/proc_hier_top.sv
// Single-cycle 16-bit processor core: fetch, decode, execute and commit in one clock.
// External combinational instruction/data memories; combinational commit-trace outputs.
module proc_hier_top (
   input  logic        clk,
   input  logic        rst,
   output logic [15:0] inst_addr,
   input  logic [15:0] inst_data,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   input  logic [15:0] mem_rdata,
   output logic        mem_rd,
   output logic        mem_wr,
   output logic [15:0] trc_pc,
   output logic [15:0] trc_inst,
   output logic        trc_regwrite,
   output logic [2:0]  trc_wreg,
   output logic [15:0] trc_wdata,
   output logic        halt,
   output logic [31:0] cycle_count
);

   typedef enum logic [0:0] {
      ST_RUN    = 1'b0,
      ST_HALTED = 1'b1
   } state_t;

   localparam logic [4:0] OP_HALT  = 5'b00000;
   localparam logic [4:0] OP_ADDI  = 5'b01000;
   localparam logic [4:0] OP_SUBI  = 5'b01001;
   localparam logic [4:0] OP_XORI  = 5'b01010;
   localparam logic [4:0] OP_ANDNI = 5'b01011;
   localparam logic [4:0] OP_ST    = 5'b10000;
   localparam logic [4:0] OP_LD    = 5'b10001;
   localparam logic [4:0] OP_STU   = 5'b10011;
   localparam logic [4:0] OP_RTYPE = 5'b11011;
   localparam logic [4:0] OP_LBI   = 5'b11000;
   localparam logic [4:0] OP_BEQZ  = 5'b01100;
   localparam logic [4:0] OP_BNEZ  = 5'b01101;
   localparam logic [4:0] OP_J     = 5'b00100;

   state_t      state_r, state_nxt_s;
   logic [15:0] pc_r, pc_nxt_s;
   logic [15:0] regs_r [8];
   logic [31:0] cycle_r;

   logic [4:0]  opcode_s;
   logic [15:0] rs_val_s, rt_val_s;
   logic [15:0] sext5_s, zext5_s, sext8_s, sext11_s;
   logic [15:0] pc_inc_s, addr_sum_s, alu_s, wdata_s;
   logic [2:0]  wreg_s;
   logic        wen_s, rd_s, wr_s, halt_s;

   assign opcode_s   = inst_data[15:11];
   assign rs_val_s   = regs_r[inst_data[10:8]];
   assign rt_val_s   = regs_r[inst_data[7:5]];
   assign sext5_s    = {{11{inst_data[4]}}, inst_data[4:0]};
   assign zext5_s    = {11'd0, inst_data[4:0]};
   assign sext8_s    = {{8{inst_data[7]}}, inst_data[7:0]};
   assign sext11_s   = {{5{inst_data[10]}}, inst_data[10:0]};
   assign pc_inc_s   = pc_r + 16'd2;
   assign addr_sum_s = rs_val_s + sext5_s;

   // Decode/execute: next state, next PC, writeback and memory strobes
   always_comb begin
      state_nxt_s = state_r;
      pc_nxt_s    = pc_inc_s;
      alu_s       = addr_sum_s;
      wen_s       = 1'b0;
      wreg_s      = inst_data[7:5];
      wdata_s     = 16'h0000;
      rd_s        = 1'b0;
      wr_s        = 1'b0;
      halt_s      = 1'b0;
      if (state_r == ST_HALTED) begin
         halt_s   = 1'b1;
         pc_nxt_s = pc_r;
      end else begin
         case (opcode_s)
            OP_HALT: begin
               halt_s      = 1'b1;
               pc_nxt_s    = pc_r;
               state_nxt_s = ST_HALTED;
            end
            OP_ADDI: begin
               wen_s   = 1'b1;
               wdata_s = alu_s;
            end
            OP_SUBI: begin
               alu_s   = sext5_s - rs_val_s;
               wen_s   = 1'b1;
               wdata_s = alu_s;
            end
            OP_XORI: begin
               alu_s   = rs_val_s ^ zext5_s;
               wen_s   = 1'b1;
               wdata_s = alu_s;
            end
            OP_ANDNI: begin
               alu_s   = rs_val_s & ~zext5_s;
               wen_s   = 1'b1;
               wdata_s = alu_s;
            end
            OP_ST: wr_s = 1'b1;
            OP_LD: begin
               rd_s    = 1'b1;
               wen_s   = 1'b1;
               wdata_s = mem_rdata;
            end
            OP_STU: begin
               wr_s    = 1'b1;
               wen_s   = 1'b1;
               wreg_s  = inst_data[10:8];
               wdata_s = alu_s;
            end
            OP_RTYPE: begin
               case (inst_data[1:0])
                  2'b00:   alu_s = rs_val_s + rt_val_s;
                  2'b01:   alu_s = rt_val_s - rs_val_s;
                  2'b10:   alu_s = rs_val_s ^ rt_val_s;
                  2'b11:   alu_s = rs_val_s & ~rt_val_s;
                  default: alu_s = rs_val_s + rt_val_s;
               endcase
               wen_s   = 1'b1;
               wreg_s  = inst_data[4:2];
               wdata_s = alu_s;
            end
            OP_LBI: begin
               alu_s   = sext8_s;
               wen_s   = 1'b1;
               wreg_s  = inst_data[10:8];
               wdata_s = sext8_s;
            end
            OP_BEQZ: begin
               if (rs_val_s == 16'h0000) pc_nxt_s = pc_inc_s + sext8_s;
               else                      pc_nxt_s = pc_inc_s;
            end
            OP_BNEZ: begin
               if (rs_val_s != 16'h0000) pc_nxt_s = pc_inc_s + sext8_s;
               else                      pc_nxt_s = pc_inc_s;
            end
            OP_J:    pc_nxt_s = pc_inc_s + sext11_s;
            default: pc_nxt_s = pc_inc_s;
         endcase
      end
   end

   // PC, run/halted state and free-running cycle counter
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= ST_RUN;
         pc_r    <= 16'h0000;
         cycle_r <= 32'd0;
      end else begin
         state_r <= state_nxt_s;
         pc_r    <= pc_nxt_s;
         cycle_r <= cycle_r + 32'd1;
      end
   end

   // Register file write port
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 8; i++) regs_r[i] <= 16'h0000;
      end else if (wen_s) begin
         regs_r[wreg_s] <= wdata_s;
      end
   end

   // Strobes are forced low while reset is held so nothing is seen to commit
   assign inst_addr    = pc_r;
   assign trc_pc       = pc_r;
   assign trc_inst     = inst_data;
   assign mem_addr     = alu_s;
   assign mem_wdata    = rt_val_s;
   assign mem_rd       = rd_s & rst;
   assign mem_wr       = wr_s & rst;
   assign trc_regwrite = wen_s & rst;
   assign trc_wreg     = wreg_s;
   assign trc_wdata    = wdata_s;
   assign halt         = halt_s & rst;
   assign cycle_count  = cycle_r;

endmodule

// File: tb/tb_proc_hier_top.sv
// Directed table-driven bench for proc_hier_top: a straight-line program with
// hand-computed commit expectations, then halt-hold and mid-run reset sequences.
module tb_proc_hier_top;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] inst_addr, inst_data, mem_addr, mem_wdata, mem_rdata;
   logic        mem_rd, mem_wr, trc_regwrite, halt;
   logic [15:0] trc_pc, trc_inst, trc_wdata;
   logic [2:0]  trc_wreg;
   logic [31:0] cycle_count;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [15:0] inst;
      logic [15:0] rdata;
      logic [15:0] pc;
      logic        rw;
      logic [2:0]  wreg;
      logic [15:0] wdata;
      logic        mrd;
      logic        mwr;
      logic [15:0] maddr;
      logic [15:0] mwdata;
      logic        hlt;
   } vec_t;

   vec_t vecs[$];

   proc_hier_top dut (
      .clk(clk), .rst(rst), .inst_addr(inst_addr), .inst_data(inst_data),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .mem_rd(mem_rd), .mem_wr(mem_wr), .trc_pc(trc_pc), .trc_inst(trc_inst),
      .trc_regwrite(trc_regwrite), .trc_wreg(trc_wreg), .trc_wdata(trc_wdata),
      .halt(halt), .cycle_count(cycle_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic add(input logic [15:0] inst, input logic [15:0] rdata, input logic [15:0] pc,
                      input logic rw, input logic [2:0] wreg, input logic [15:0] wdata,
                      input logic mrd, input logic mwr, input logic [15:0] maddr,
                      input logic [15:0] mwdata, input logic hlt);
      vec_t v;
      v = '{inst, rdata, pc, rw, wreg, wdata, mrd, mwr, maddr, mwdata, hlt};
      vecs.push_back(v);
   endtask

   initial begin
      //  inst      rdata     pc        rw    wreg  wdata     rd    wr    addr      wdata     halt
      add(16'hC1FD, 16'h0000, 16'h0000, 1'b1, 3'd1, 16'hFFFD, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
      add(16'hC105, 16'h0000, 16'h0002, 1'b1, 3'd1, 16'h0005, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
      add(16'hC207, 16'h0000, 16'h0004, 1'b1, 3'd2, 16'h0007, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
      add(16'hD94C, 16'h0000, 16'h0006, 1'b1, 3'd3, 16'h000C, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
      add(16'hD94D, 16'h0000, 16'h0008, 1'b1, 3'd3, 16'h0002, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
      add(16'hD94E, 16'h0000, 16'h000A, 1'b1, 3'd3, 16'h0002, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
      add(16'hD94F, 16'h0000, 16'h000C, 1'b1, 3'd3, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
      add(16'h419F, 16'h0000, 16'h000E, 1'b1, 3'd4, 16'h0004, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
      add(16'h4983, 16'h0000, 16'h0010, 1'b1, 3'd4, 16'hFFFE, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
      add(16'h52BF, 16'h0000, 16'h0012, 1'b1, 3'd5, 16'h0018, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
      add(16'h5AA3, 16'h0000, 16'h0014, 1'b1, 3'd5, 16'h0004, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
      add(16'hC110, 16'h0000, 16'h0016, 1'b1, 3'd1, 16'h0010, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
      add(16'h8940, 16'hABCD, 16'h0018, 1'b1, 3'd2, 16'hABCD, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0);
      add(16'h8142, 16'h0000, 16'h001A, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 16'h0012, 16'hABCD, 1'b0);
      add(16'h8982, 16'hABCD, 16'h001C, 1'b1, 3'd4, 16'hABCD, 1'b1, 1'b0, 16'h0012, 16'h0000, 1'b0);
      add(16'h995F, 16'h0000, 16'h001E, 1'b1, 3'd1, 16'h000F, 1'b0, 1'b1, 16'h000F, 16'hABCD, 1'b0);
      add(16'h0800, 16'h0000, 16'h0020, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
      add(16'h41C0, 16'h0000, 16'h0022, 1'b1, 3'd6, 16'h000F, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
      add(16'hC100, 16'h0000, 16'h0024, 1'b1, 3'd1, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
      add(16'h6104, 16'h0000, 16'h0026, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
      add(16'h6904, 16'h0000, 16'h002C, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
      add(16'hC101, 16'h0000, 16'h002E, 1'b1, 3'd1, 16'h0001, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
      add(16'h69FC, 16'h0000, 16'h0030, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
      add(16'h6108, 16'h0000, 16'h002E, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
      add(16'h27FE, 16'h0000, 16'h0030, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
      add(16'h2006, 16'h0000, 16'h0030, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
      add(16'hF800, 16'h0000, 16'h0038, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
      add(16'h0000, 16'h0000, 16'h003A, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);

      // Reset state: strobes must stay low even with store/write instructions presented
      rst       = 1'b0;
      inst_data = 16'h8142;
      mem_rdata = 16'h0000;
      #2;
      chk("rst_pc", {16'h0, trc_pc}, 32'h0000);
      chk("rst_iaddr", {16'h0, inst_addr}, 32'h0000);
      chk("rst_cycle", cycle_count, 32'd0);
      chk("rst_memwr", {31'd0, mem_wr}, 32'd0);
      inst_data = 16'hC1FD;
      #1;
      chk("rst_regwrite", {31'd0, trc_regwrite}, 32'd0);
      chk("rst_halt", {31'd0, halt}, 32'd0);
      @(negedge clk);
      rst = 1'b1;

      foreach (vecs[i]) begin
         inst_data = vecs[i].inst;
         mem_rdata = vecs[i].rdata;
         #1;
         chk($sformatf("v%0d_pc", i), {16'h0, trc_pc}, {16'h0, vecs[i].pc});
         chk($sformatf("v%0d_iaddr", i), {16'h0, inst_addr}, {16'h0, vecs[i].pc});
         chk($sformatf("v%0d_tinst", i), {16'h0, trc_inst}, {16'h0, vecs[i].inst});
         chk($sformatf("v%0d_cycle", i), cycle_count, i);
         chk($sformatf("v%0d_rw", i), {31'd0, trc_regwrite}, {31'd0, vecs[i].rw});
         chk($sformatf("v%0d_mrd", i), {31'd0, mem_rd}, {31'd0, vecs[i].mrd});
         chk($sformatf("v%0d_mwr", i), {31'd0, mem_wr}, {31'd0, vecs[i].mwr});
         chk($sformatf("v%0d_halt", i), {31'd0, halt}, {31'd0, vecs[i].hlt});
         if (vecs[i].rw) begin
            chk($sformatf("v%0d_wreg", i), {29'd0, trc_wreg}, {29'd0, vecs[i].wreg});
            chk($sformatf("v%0d_wdata", i), {16'h0, trc_wdata}, {16'h0, vecs[i].wdata});
         end
         if (vecs[i].mrd || vecs[i].mwr)
            chk($sformatf("v%0d_maddr", i), {16'h0, mem_addr}, {16'h0, vecs[i].maddr});
         if (vecs[i].mwr)
            chk($sformatf("v%0d_mwdata", i), {16'h0, mem_wdata}, {16'h0, vecs[i].mwdata});
         @(posedge clk);
         @(negedge clk);
      end

      // Halted: PC frozen, no writes even for write-type instructions, counter runs
      for (int k = 0; k < 6; k++) begin
         inst_data = (k % 2 == 0) ? 16'hC1FD : 16'h8142;
         #1;
         chk($sformatf("h%0d_pc", k), {16'h0, trc_pc}, 32'h003A);
         chk($sformatf("h%0d_halt", k), {31'd0, halt}, 32'd1);
         chk($sformatf("h%0d_rw", k), {31'd0, trc_regwrite}, 32'd0);
         chk($sformatf("h%0d_mwr", k), {31'd0, mem_wr}, 32'd0);
         chk($sformatf("h%0d_cycle", k), cycle_count, 28 + k);
         @(posedge clk);
         @(negedge clk);
      end

      // Asynchronous reset mid-run clears PC, halt and counter immediately
      inst_data = 16'hC1FD;
      #2;
      rst = 1'b0;
      #1;
      chk("mrst_pc", {16'h0, trc_pc}, 32'h0000);
      chk("mrst_halt", {31'd0, halt}, 32'd0);
      chk("mrst_cycle", cycle_count, 32'd0);
      chk("mrst_rw", {31'd0, trc_regwrite}, 32'd0);
      @(negedge clk);
      rst       = 1'b1;
      inst_data = 16'h41C0;
      #1;
      chk("post_pc", {16'h0, trc_pc}, 32'h0000);
      chk("post_rw", {31'd0, trc_regwrite}, 32'd1);
      chk("post_wreg", {29'd0, trc_wreg}, 32'd6);
      chk("post_wdata_r1_cleared", {16'h0, trc_wdata}, 32'h0000);
      @(posedge clk);
      @(negedge clk);
      chk("post_pc2", {16'h0, trc_pc}, 32'h0002);
      chk("post_cycle1", cycle_count, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
